// File: rtl/hc_mmio_rd_responder_pkg.sv
// HardCloud CSR read-side definitions: CCI-P MMIO types, register offsets and the read selector.
// The optional perf counters (HC_MMIO_RD_PERF_EN) live in the responder top.
package hc_mmio_rd_responder_pkg;

  localparam int HC_BUFFER_SIZE = 3;

  localparam logic [15:0] HC_DFH          = 16'h000;
  localparam logic [15:0] HC_AFU_ID_L     = 16'h008;
  localparam logic [15:0] HC_AFU_ID_H     = 16'h010;
  localparam logic [15:0] HC_DSM_BASE     = 16'h110;
  localparam logic [15:0] HC_CONTROL      = 16'h118;
  localparam logic [15:0] HC_BUFFER_BASE  = 16'h120;
  localparam logic [15:0] HC_STATUS       = 16'h180;
  localparam logic [15:0] HC_ERR_CNT      = 16'h188;
  localparam logic [15:0] HC_PERF_CYCLES  = 16'h190;
  localparam logic [15:0] HC_PERF_READS   = 16'h198;
  localparam logic [15:0] HC_MMIO_RD_LIMIT = 16'h400;

  localparam logic [63:0] HC_DFH_VALUE = {4'h1, 8'h0, 4'h0, 7'h0, 1'b1, 16'h0, 24'h0};

  typedef struct packed {
    logic [1:0]  vc_used;
    logic        rsvd1;
    logic        hit_miss;
    logic [1:0]  rsvd0;
    logic [1:0]  cl_num;
    logic [3:0]  resp_type;
    logic [15:0] mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    logic [15:0] address;
    logic [1:0]  length;
    logic        rsvd0;
    logic [8:0]  tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    logic [511:0]       data;
    logic               rspValid;
    logic               mmioRdValid;
    logic               mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    logic [8:0] tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    logic [63:0]         data;
  } t_if_ccip_c2_Tx;

  typedef struct packed {
    logic [63:0] address;
    logic [31:0] size;
  } t_hc_buffer;

  typedef struct packed {
    logic [8:0]  tid;
    logic [15:0] address;
    logic [1:0]  length;
  } t_hc_rd_req;

  typedef enum logic [3:0] {
    HC_SEL_ZERO, HC_SEL_DFH, HC_SEL_ID_L, HC_SEL_ID_H, HC_SEL_DSM, HC_SEL_CONTROL,
    HC_SEL_BUF_ADDR, HC_SEL_BUF_SIZE, HC_SEL_STATUS, HC_SEL_ERR_CNT,
    HC_SEL_PERF_CYCLES, HC_SEL_PERF_READS
  } t_hc_rd_sel;

  // Byte offset (64-bit aligned) to register select; fixed registers win over the buffer window.
  function automatic t_hc_rd_sel hc_mmio_rd_sel(input logic [15:0] offset,
                                                input int unsigned num_buffers);
    t_hc_rd_sel sel;
    sel = HC_SEL_ZERO;
    case (offset)
      HC_DFH:         sel = HC_SEL_DFH;
      HC_AFU_ID_L:    sel = HC_SEL_ID_L;
      HC_AFU_ID_H:    sel = HC_SEL_ID_H;
      HC_DSM_BASE:    sel = HC_SEL_DSM;
      HC_CONTROL:     sel = HC_SEL_CONTROL;
      HC_STATUS:      sel = HC_SEL_STATUS;
      HC_ERR_CNT:     sel = HC_SEL_ERR_CNT;
      HC_PERF_CYCLES: sel = HC_SEL_PERF_CYCLES;
      HC_PERF_READS:  sel = HC_SEL_PERF_READS;
      default:        sel = HC_SEL_ZERO;
    endcase
    if (sel == HC_SEL_ZERO && offset >= HC_BUFFER_BASE &&
        {16'h0, offset} < 32'(HC_BUFFER_BASE) + (num_buffers << 4))
      sel = offset[3] ? HC_SEL_BUF_SIZE : HC_SEL_BUF_ADDR;
    return sel;
  endfunction

endpackage

// File: rtl/hc_mmio_rd_mux.sv
// Combinational HardCloud CSR read map: 64-bit aligned byte offset to register value.
// Kept standalone so individual AFUs can extend the map.
module hc_mmio_rd_mux
  import hc_mmio_rd_responder_pkg::*;
#(
  parameter logic [63:0] AFU_ID_H    = 64'h0,
  parameter logic [63:0] AFU_ID_L    = 64'h0,
  parameter int          NUM_BUFFERS = HC_BUFFER_SIZE
) (
  input  logic [15:0] offset,
  input  logic [63:0] dsm_base,
  input  logic [31:0] control,
  input  t_hc_buffer  buffers [NUM_BUFFERS],
  input  logic [63:0] status,
  input  logic [31:0] err_cnt,
  input  logic [63:0] perf_cycles,
  input  logic [31:0] perf_reads,
  output logic [63:0] value
);

  t_hc_rd_sel  sel;
  logic [11:0] buf_idx;

  assign buf_idx = offset[15:4] - HC_BUFFER_BASE[15:4];

  always_comb begin
    value = '0;
    sel   = hc_mmio_rd_sel(offset, NUM_BUFFERS);
    case (sel)
      HC_SEL_DFH:         value = HC_DFH_VALUE;
      HC_SEL_ID_L:        value = AFU_ID_L;
      HC_SEL_ID_H:        value = AFU_ID_H;
      HC_SEL_DSM:         value = dsm_base;
      HC_SEL_CONTROL:     value = {32'h0, control};
      HC_SEL_STATUS:      value = status;
      HC_SEL_ERR_CNT:     value = {32'h0, err_cnt};
      HC_SEL_PERF_CYCLES: value = perf_cycles;
      HC_SEL_PERF_READS:  value = {32'h0, perf_reads};
      HC_SEL_BUF_ADDR, HC_SEL_BUF_SIZE: begin
        for (int unsigned i = 0; i < NUM_BUFFERS; i++) begin
          if (buf_idx == 12'(i))
            value = (sel == HC_SEL_BUF_ADDR) ? buffers[i].address : {32'h0, buffers[i].size};
        end
      end
      default:            value = '0;
    endcase
  end

endmodule

// File: rtl/hc_mmio_rd_responder.sv
// HardCloud MMIO read responder: c0 Rx MMIO read -> c2 Tx response two cycles later.
// Optional perf counters at 0x190/0x198 are built only when HC_MMIO_RD_PERF_EN is defined.
module hc_mmio_rd_responder
  import hc_mmio_rd_responder_pkg::*;
#(
  parameter logic [63:0] AFU_ID_H    = 64'h0,
  parameter logic [63:0] AFU_ID_L    = 64'h0,
  parameter int          NUM_BUFFERS = HC_BUFFER_SIZE
) (
  input  logic           clk,
  input  logic           reset,
  input  t_if_ccip_c0_Rx rx_mmio,
  output t_if_ccip_c2_Tx tx_mmio,
  input  logic [63:0]    dsm_base,
  input  logic [31:0]    control,
  input  t_hc_buffer     buffers [NUM_BUFFERS],
  input  logic [63:0]    status
);

  t_ccip_c0_ReqMmioHdr rx_hdr;
  logic                accept;
  logic                s0_valid;
  t_hc_rd_req          s0_req;
  logic [15:0]         offset;
  logic [63:0]         reg_value;
  logic [63:0]         rd_data;
  logic                rd_err;
  logic [31:0]         err_cnt;
  logic [63:0]         perf_cycles;
  logic [31:0]         perf_reads;
  logic                unused_bits;

  assign rx_hdr = t_ccip_c0_ReqMmioHdr'(rx_mmio.hdr);
  assign accept = rx_mmio.mmioRdValid && (rx_hdr.address < HC_MMIO_RD_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_valid <= 1'b0;
      s0_req   <= '0;
    end else begin
      s0_valid <= accept;
      if (accept)
        s0_req <= '{tid: rx_hdr.tid, address: rx_hdr.address, length: rx_hdr.length};
    end
  end

  // Accepted dword addresses are below 0x400, so bits [12:1] cover every 64-bit register.
  assign offset = {1'b0, s0_req.address[12:1], 3'b000};

  hc_mmio_rd_mux #(
    .AFU_ID_H    (AFU_ID_H),
    .AFU_ID_L    (AFU_ID_L),
    .NUM_BUFFERS (NUM_BUFFERS)
  ) u_mux (
    .offset      (offset),
    .dsm_base    (dsm_base),
    .control     (control),
    .buffers     (buffers),
    .status      (status),
    .err_cnt     (err_cnt),
    .perf_cycles (perf_cycles),
    .perf_reads  (perf_reads),
    .value       (reg_value)
  );

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (s0_req.length)
      2'd0:    rd_data = {32'h0, s0_req.address[0] ? reg_value[63:32] : reg_value[31:0]};
      2'd1:    if (s0_req.address[0]) rd_err = 1'b1;
               else                   rd_data = reg_value;
      default: rd_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt <= '0;
    end else if (s0_valid && rd_err && err_cnt != '1) begin
      err_cnt <= err_cnt + 32'd1;
    end
  end

  // Header and data hold their last response between reads; only the valid pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_mmio <= '0;
    end else begin
      tx_mmio.mmioRdValid <= s0_valid;
      if (s0_valid) begin
        tx_mmio.hdr.tid <= s0_req.tid;
        tx_mmio.data    <= rd_data;
      end
    end
  end

`ifdef HC_MMIO_RD_PERF_EN
  // Reads are counted as they leave S1, so a read of 0x198 sees only earlier reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cycles <= '0;
      perf_reads  <= '0;
    end else begin
      perf_cycles <= perf_cycles + 64'd1;
      if (s0_valid)
        perf_reads <= perf_reads + 32'd1;
    end
  end
`else
  assign perf_cycles = '0;
  assign perf_reads  = '0;
`endif

  assign unused_bits = ^{rx_mmio.data, rx_mmio.rspValid, rx_mmio.mmioWrValid,
                         rx_hdr.rsvd0, s0_req.address[15:13]};

endmodule

// File: tb/tb_hc_mmio_rd_responder.sv
// Self-checking bench for hc_mmio_rd_responder: vector table plus hand-written reset/filter/perf sequences.
module tb_hc_mmio_rd_responder;
  import hc_mmio_rd_responder_pkg::*;

  localparam logic [63:0] ID_H = 64'hCAFE_F00D_89AB_CDEF;
  localparam logic [63:0] ID_L = 64'hDEAD_BEEF_0123_4567;
  localparam int          NB   = 3;

  logic           clk = 1'b0;
  logic           reset;
  t_if_ccip_c0_Rx rx_mmio;
  t_if_ccip_c2_Tx tx_mmio;
  logic [63:0]    dsm_base;
  logic [31:0]    control;
  t_hc_buffer     buffers [NB];
  logic [63:0]    status;

  hc_mmio_rd_responder #(
    .AFU_ID_H    (ID_H),
    .AFU_ID_L    (ID_L),
    .NUM_BUFFERS (NB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_mmio  (rx_mmio),
    .tx_mmio  (tx_mmio),
    .dsm_base (dsm_base),
    .control  (control),
    .buffers  (buffers),
    .status   (status)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [8:0]  tid;
    logic [63:0] data;
    bit          chk_data;
    int unsigned due;
  } exp_t;

  typedef struct {
    logic [15:0] addr;
    logic [1:0]  len;
    logic [8:0]  tid;
    logic [63:0] exp;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[$];
  logic [63:0] captured[$];
  exp_t        mon_e;
  int          compared   = 0;
  int          mismatched = 0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: every valid must match the oldest outstanding request.
  always @(negedge clk) begin
    if (tx_mmio.mmioRdValid === 1'b1) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_rsp: got response tid %h data %h, expected no response",
                 tx_mmio.hdr.tid, tx_mmio.data);
      end else begin
        mon_e = sb.pop_front();
        check64("rsp_tid", 64'(tx_mmio.hdr.tid), 64'(mon_e.tid));
        check64("rsp_latency", 64'(cyc), 64'(mon_e.due));
        if (mon_e.chk_data) check64("rsp_data", tx_mmio.data, mon_e.data);
        else                captured.push_back(tx_mmio.data);
      end
    end
  end

  task automatic drive(input logic [15:0] addr, input logic [1:0] len, input logic [8:0] tid);
    t_ccip_c0_ReqMmioHdr h;
    h = '0;
    h.address = addr;
    h.length  = len;
    h.tid     = tid;
    rx_mmio.hdr         = t_ccip_c0_RspMemHdr'(h);
    rx_mmio.mmioRdValid = 1'b1;
  endtask

  task automatic req(input logic [15:0] addr, input logic [1:0] len, input logic [8:0] tid,
                     input logic [63:0] exp, input bit chk, input bit expect_rsp);
    @(negedge clk);
    drive(addr, len, tid);
    if (expect_rsp) sb.push_back('{tid: tid, data: exp, chk_data: chk, due: cyc + 2});
  endtask

  task automatic idle();
    @(negedge clk);
    rx_mmio.mmioRdValid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: got %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    rx_mmio  = '0;
    dsm_base = 64'h0000_00AB_CDEF_0040;
    control  = 32'hA5A5_0003;
    status   = 64'h0000_0000_0302_0001;
    buffers[0] = '{address: 64'h0000_0000_0000_1000, size: 32'h0000_4000};
    buffers[1] = '{address: 64'h0000_0000_0000_2000, size: 32'h0000_0055};
    buffers[2] = '{address: 64'h1234_5678_9ABC_DEF0, size: 32'h0000_0ABC};

    vecs.push_back('{16'h000, 2'd1, 9'h005, 64'h1000_0100_0000_0000});
    vecs.push_back('{16'h002, 2'd1, 9'h006, 64'hDEAD_BEEF_0123_4567});
    vecs.push_back('{16'h004, 2'd1, 9'h007, 64'hCAFE_F00D_89AB_CDEF});
    vecs.push_back('{16'h005, 2'd0, 9'h008, 64'h0000_0000_CAFE_F00D});
    vecs.push_back('{16'h006, 2'd1, 9'h009, 64'h0});
    vecs.push_back('{16'h044, 2'd1, 9'h00A, 64'h0000_00AB_CDEF_0040});
    vecs.push_back('{16'h046, 2'd0, 9'h010, 64'h0000_0000_A5A5_0003});
    vecs.push_back('{16'h047, 2'd0, 9'h011, 64'h0});
    vecs.push_back('{16'h050, 2'd1, 9'h012, 64'h1234_5678_9ABC_DEF0});
    vecs.push_back('{16'h051, 2'd0, 9'h013, 64'h0000_0000_1234_5678});
    vecs.push_back('{16'h04A, 2'd1, 9'h014, 64'h0000_0000_0000_4000});
    vecs.push_back('{16'h052, 2'd0, 9'h015, 64'h0000_0000_0000_0ABC});
    vecs.push_back('{16'h054, 2'd1, 9'h016, 64'h0});
    vecs.push_back('{16'h060, 2'd1, 9'h017, 64'h0000_0000_0302_0001});
    vecs.push_back('{16'h3FF, 2'd0, 9'h018, 64'h0});
`ifndef HC_MMIO_RD_PERF_EN
    vecs.push_back('{16'h064, 2'd1, 9'h100, 64'h0});
    vecs.push_back('{16'h066, 2'd1, 9'h101, 64'h0});
`endif
    vecs.push_back('{16'h003, 2'd1, 9'h019, 64'h0});
    vecs.push_back('{16'h062, 2'd1, 9'h01A, 64'h1});
    vecs.push_back('{16'h000, 2'd2, 9'h01B, 64'h0});
    vecs.push_back('{16'h001, 2'd3, 9'h01C, 64'h0});
    vecs.push_back('{16'h062, 2'd0, 9'h01D, 64'h3});
    vecs.push_back('{16'h063, 2'd0, 9'h01E, 64'h0});
    vecs.push_back('{16'h0C0, 2'd1, 9'h01F, 64'h0});
    vecs.push_back('{16'h062, 2'd1, 9'h1FF, 64'h3});

    repeat (3) @(negedge clk);
    check64("reset_valid", 64'(tx_mmio.mmioRdValid), 64'h0);
    check64("reset_tid",   64'(tx_mmio.hdr.tid),     64'h0);
    check64("reset_data",  tx_mmio.data,             64'h0);
    reset = 1'b0;

    foreach (vecs[i]) req(vecs[i].addr, vecs[i].len, vecs[i].tid, vecs[i].exp, 1'b1, 1'b1);
    idle();
    drain();

    // Out-of-range reads belong to another handler and must never be answered.
    req(16'h0400, 2'd1, 9'h0AA, 64'h0, 1'b1, 1'b0);
    req(16'hFFFF, 2'd0, 9'h0AB, 64'h0, 1'b1, 1'b0);
    idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check64("filter_no_rsp", 64'(tx_mmio.mmioRdValid), 64'h0);
    end

    // Reset in the cycle after acceptance drops the read and clears the held response.
    req(16'h046, 2'd1, 9'h1AB, 64'h0, 1'b1, 1'b0);
    @(negedge clk);
    rx_mmio.mmioRdValid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check64("rst_flight_valid", 64'(tx_mmio.mmioRdValid), 64'h0);
    check64("rst_flight_tid",   64'(tx_mmio.hdr.tid),     64'h0);
    check64("rst_flight_data",  tx_mmio.data,             64'h0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check64("rst_no_rsp", 64'(tx_mmio.mmioRdValid), 64'h0);
    end

`ifdef HC_MMIO_RD_PERF_EN
    for (int i = 0; i < 3; i++) req(16'h000, 2'd1, 9'(9'h040 + i), 64'h1000_0100_0000_0000, 1'b1, 1'b1);
    req(16'h066, 2'd1, 9'h043, 64'h3, 1'b1, 1'b1);
    req(16'h064, 2'd1, 9'h044, 64'h0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) idle();
    req(16'h064, 2'd1, 9'h045, 64'h0, 1'b0, 1'b1);
    idle();
    drain();
    check64("perf_samples", 64'(captured.size()), 64'd2);
    if (captured.size() == 2) check64("perf_cycle_delta", captured[1] - captured[0], 64'd10);
`endif

    req(16'h062, 2'd1, 9'h050, 64'h0, 1'b1, 1'b1);
    idle();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hc_mmio_rd_responder.md
Name: hc_mmio_rd_responder

Overview:
- MMIO read responder for the HardCloud CSR space; the read-side counterpart of the existing MMIO write decode (DSM base, control, buffer address/size).
- Accepts CCI-P MMIO read requests on c0 Rx and returns data on c2 Tx with the original tid.
- Fixed 2-cycle pipeline with no backpressure; sits beside the write-decode logic in each HardCloud AFU top.

Parameters:
- AFU_ID_H, 64'h0, upper 64 bits of the AFU UUID, returned at 0x010.
- AFU_ID_L, 64'h0, lower 64 bits of the AFU UUID, returned at 0x008.
- NUM_BUFFERS, HC_BUFFER_SIZE (3), number of buffer descriptors exposed.

Ports:
- clk  in  1  AFU clock.
- reset  in  1  synchronous, active-high reset.
- rx_mmio  in  t_if_ccip_c0_Rx  c0 Rx; only mmioRdValid and hdr (as t_ccip_c0_ReqMmioHdr) are used.
- tx_mmio  out  t_if_ccip_c2_Tx  c2 Tx: mmioRdValid, hdr.tid, data[63:0].
- dsm_base  in  64  current DSM base register.
- control  in  32  current HC control register.
- buffers  in  t_hc_buffer [NUM_BUFFERS]  current buffer descriptors.
- status  in  64  AFU status word ({rd_state, wr_state, done, ...}, owned by the AFU).

Behaviour:
- Reset: tx_mmio.mmioRdValid=0, hdr=0, data=0; pipeline valids cleared; error counter=0.
- Any read in flight when reset asserts is dropped; no response is issued for it.
- Accept condition: rx_mmio.mmioRdValid && hdr.address < 'h400 (dword address). Other reads are ignored and get no response (another handler owns them).
- S0 (accept cycle, registered): capture tid[8:0], address[15:0], length[1:0]. A new request can be accepted every cycle.
- S1: decode the 64-bit aligned register (byte = {address[15:1],3'b0}) and register the read value.
- S2: drive tx_mmio.mmioRdValid=1 for exactly one cycle with the captured tid.
- Latency: request in cycle N → response valid in cycle N+2. Back-to-back requests produce back-to-back responses in order.
- Register map (byte offsets):
  - 0x000: DFH = {4'h1, 8'h0, 4'h0, 7'h0, 1'b1, 16'h0, 24'h0}. Type AFU, EOL=1.
  - 0x008: AFU_ID_L. 0x010: AFU_ID_H. 0x018 and 0x020: 0.
  - 0x110: dsm_base. 0x118: {32'h0, control}.
  - 0x120+0x10*i: buffers[i].address. 0x128+0x10*i: {32'h0, buffers[i].size}, for i < NUM_BUFFERS.
  - 0x180: status. 0x188: {32'h0, err_cnt}.
  - Any other offset below 0x1000: 0.
- Length handling:
  - length=0 (4B): data[31:0] = address[0] ? reg[63:32] : reg[31:0]; data[63:32] = 0.
  - length=1 (8B) with address[0]=0: data = full reg.
  - length=1 with address[0]=1, or length ≥ 2: data = 0; err_cnt += 1.
- err_cnt is 32 bits and saturates at 32'hFFFF_FFFF (no wrap).
- Input registers are sampled in S1. A write landing in the same cycle as S1 returns the pre-write value.

Optional Feature:
- Macro HC_MMIO_RD_PERF_EN.
- When defined:
  - 64-bit free-running cycle counter, readable at 0x190; cleared by reset, wraps at 2^64.
  - 32-bit counter of accepted reads, readable at 0x198; wraps.
- When undefined: counters are not instantiated; 0x190 and 0x198 read 0.

Decomposition:
- Add to the HardCloud package:
  - HC_STATUS = 16'h180, HC_ERR_CNT = 16'h188, HC_PERF_CYCLES = 16'h190, HC_PERF_READS = 16'h198.
  - HC_DFH_VALUE.
  - t_hc_rd_req struct {tid, address, length}.
  - Function hc_mmio_rd_sel (read counterpart of the write selectors).
- Sub-module hc_mmio_rd_mux: combinational offset → 64-bit value map, kept separate so each AFU can extend the map. Pipeline, length handling and counters stay in the top.

Test Plan:
- Read DFH: 8B read, address 0x000, tid 0x05 → cycle N+2: valid=1, tid=0x05, data=HC_DFH_VALUE.
- Back-to-back reads: 4B reads of dword 0x46 then 0x47 (offset 0x118, both halves), control=32'hA5A5_0003, consecutive cycles, tids 0x10/0x11 → consecutive responses: data 0xA5A5_0003 then 0x0.
- Buffer readback: buffers[2].address=64'h1234_5678_9ABC_DEF0, 8B read at dword 0x50 (offset 0x140) → data = that value; 4B read at dword 0x51 → 0x1234_5678.
- Misaligned and unmapped:
  - 8B read at dword 0x03 → data 0, err_cnt reads 1 at 0x188.
  - Read at offset 0x300 → 0, err_cnt unchanged.
- Range filter and reset:
  - Read at dword 0x400 → no response for 5 cycles.
  - reset asserted the cycle after accepting a read → no response; outputs 0.
- Perf (HC_MMIO_RD_PERF_EN): three reads, then read 0x198 → 3; two reads of 0x190 issued 10 cycles apart → difference 10.
